// File: rtl/seq_lock_pkg.sv
// rtl/seq_lock_pkg.sv - symbol/state encodings and code packing helper for the sequence lock
package seq_lock_pkg;

  typedef enum logic [1:0] {
    SYM_NONE = 2'b00,
    SYM_A    = 2'b01,
    SYM_B    = 2'b10,
    SYM_C    = 2'b11
  } sym_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTER   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_PROG    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  localparam int MAX_SEQ_LEN = 8;

  typedef sym_t sym_arr_t [MAX_SEQ_LEN];

  // Packs the first n symbols into a code vector, symbol 0 in the LSBs.
  function automatic logic [2*MAX_SEQ_LEN-1:0] pack_code(input sym_arr_t syms, input int n);
    logic [2*MAX_SEQ_LEN-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_SEQ_LEN; i++) begin
      if (i < n) v[2*i +: 2] = syms[i];
    end
    return v;
  endfunction

  // One-hot board LEDs ordered {LOCKOUT,PROG,OPEN,ENTER,IDLE}.
  function automatic logic [4:0] state_leds(input state_t s);
    logic [4:0] leds;
    case (s)
      ST_IDLE:    leds = 5'b00001;
      ST_ENTER:   leds = 5'b00010;
      ST_OPEN:    leds = 5'b00100;
      ST_PROG:    leds = 5'b01000;
      ST_LOCKOUT: leds = 5'b10000;
      default:    leds = 5'b00001;
    endcase
    return leds;
  endfunction

  localparam logic [2*MAX_SEQ_LEN-1:0] CODE_ABBAC =
    pack_code('{SYM_A, SYM_B, SYM_B, SYM_A, SYM_C, SYM_NONE, SYM_NONE, SYM_NONE}, 5);

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter with zero flag shared by the timed lock states
module lock_timer #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load takes priority; otherwise count down and park at zero rather than wrap.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_lock_ctrl.sv
// rtl/seq_lock_ctrl.sv - button-sequence lock controller with lockout and code programming
module seq_lock_ctrl
  import seq_lock_pkg::*;
#(
  parameter int                   SEQ_LEN        = 5,
  parameter int                   MAX_TRIES      = 3,
  parameter int                   UNLOCK_CYCLES  = 100_000_000,
  parameter int                   LOCKOUT_CYCLES = 250_000_000,
  parameter logic [2*SEQ_LEN-1:0] DEFAULT_CODE   = CODE_ABBAC[2*SEQ_LEN-1:0]
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic                           PulseA,
  input  logic                           PulseB,
  input  logic                           PulseC,
  input  logic                           ProgMode,
  output logic                           Locked,
  output logic                           Unlocked,
  output logic                           Error,
  output logic [$clog2(MAX_TRIES+1)-1:0] TriesLeft,
  output logic [4:0]                     StateLeds
);

  localparam int CODE_W  = 2 * SEQ_LEN;
  localparam int IDX_W   = $clog2(SEQ_LEN);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);
  localparam int TMAX    = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TIMER_W = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TRY_W-1:0]   TRY_MAX      = TRY_W'(MAX_TRIES);
  localparam logic [IDX_W-1:0]   IDX_LAST     = IDX_W'(SEQ_LEN - 1);

  state_t              state_q, state_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic                mismatch_q, mismatch_n;
  logic [CODE_W-1:0]   code_q, code_n;
  logic [CODE_W-1:0]   shadow_q, shadow_n;
  logic [TRY_W-1:0]    tries_q, tries_n;
  logic                error_n;
  logic                timer_load;
  logic [TIMER_W-1:0]  timer_val;
  logic                timer_zero;

  sym_t                sym;
  logic                sym_valid;
  logic [1:0]          code_sym;
  logic [CODE_W-1:0]   shadow_wr;
  logic                last_sym;
  logic                mm_acc;
  logic                open_n;

  // Decode the button pulses; anything but exactly one pulse is no symbol.
  always_comb begin
    sym = SYM_NONE;
    case ({PulseA, PulseB, PulseC})
      3'b100:  sym = SYM_A;
      3'b010:  sym = SYM_B;
      3'b001:  sym = SYM_C;
      default: sym = SYM_NONE;
    endcase
  end

  assign sym_valid = (sym != SYM_NONE);
  assign last_sym  = (idx_q == IDX_LAST);

  // Select the expected code symbol at the current entry position.
  always_comb begin
    code_sym = code_q[1:0];
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (idx_q == IDX_W'(i)) code_sym = code_q[2*i +: 2];
    end
  end

  // Shadow code with the incoming symbol written at the current position.
  always_comb begin
    shadow_wr = shadow_q;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (idx_q == IDX_W'(i)) shadow_wr[2*i +: 2] = sym;
    end
  end

  assign mm_acc = mismatch_q | (sym != code_sym);

  // Next-state and datapath updates for the lock sequencer.
  always_comb begin
    state_n    = state_q;
    idx_n      = idx_q;
    mismatch_n = mismatch_q;
    code_n     = code_q;
    shadow_n   = shadow_q;
    tries_n    = tries_q;
    error_n    = 1'b0;
    timer_load = 1'b0;
    timer_val  = '0;

    case (state_q)
      ST_IDLE: begin
        if (sym_valid) begin
          mismatch_n = (sym != code_sym);
          idx_n      = IDX_W'(1);
          state_n    = ST_ENTER;
        end
      end

      ST_ENTER: begin
        if (sym_valid) begin
          if (last_sym) begin
            idx_n      = '0;
            mismatch_n = 1'b0;
            if (!mm_acc) begin
              state_n    = ST_OPEN;
              timer_load = 1'b1;
              timer_val  = UNLOCK_LOAD;
              tries_n    = TRY_MAX;
            end else begin
              error_n = 1'b1;
              tries_n = tries_q - TRY_W'(1);
              if (tries_q == TRY_W'(1)) begin
                state_n    = ST_LOCKOUT;
                timer_load = 1'b1;
                timer_val  = LOCKOUT_LOAD;
              end else begin
                state_n = ST_IDLE;
              end
            end
          end else begin
            mismatch_n = mm_acc;
            idx_n      = idx_q + IDX_W'(1);
          end
        end
      end

      ST_OPEN: begin
        // ProgMode takes precedence even on the cycle the unlock time runs out.
        if (ProgMode) begin
          state_n = ST_PROG;
          idx_n   = '0;
        end else if (timer_zero) begin
          state_n = ST_IDLE;
        end
      end

      ST_PROG: begin
        // Dropping ProgMode aborts, even if a symbol arrives that same cycle.
        if (!ProgMode) begin
          state_n = ST_IDLE;
          idx_n   = '0;
        end else if (sym_valid) begin
          shadow_n = shadow_wr;
          if (last_sym) begin
            code_n  = shadow_wr;
            idx_n   = '0;
            state_n = ST_IDLE;
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end
      end

      ST_LOCKOUT: begin
        if (timer_zero) begin
          tries_n = TRY_MAX;
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign open_n = (state_n == ST_OPEN) || (state_n == ST_PROG);

  // State and datapath registers; code reverts to the default on reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      mismatch_q <= 1'b0;
      code_q     <= DEFAULT_CODE;
      shadow_q   <= '0;
      tries_q    <= TRY_MAX;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      mismatch_q <= mismatch_n;
      code_q     <= code_n;
      shadow_q   <= shadow_n;
      tries_q    <= tries_n;
    end
  end

  // Registered board outputs derived from the upcoming state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Locked    <= 1'b1;
      Unlocked  <= 1'b0;
      Error     <= 1'b0;
      StateLeds <= 5'b00001;
    end else begin
      Locked    <= !open_n;
      Unlocked  <= open_n;
      Error     <= error_n;
      StateLeds <= state_leds(state_n);
    end
  end

  assign TriesLeft = tries_q;

  lock_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (timer_load),
    .load_value (timer_val),
    .zero       (timer_zero)
  );

endmodule

// File: tb/tb_seq_lock_ctrl.sv
// tb/tb_seq_lock_ctrl.sv - self-checking bench for seq_lock_ctrl
module tb_seq_lock_ctrl;

  localparam int SEQ_LEN        = 5;
  localparam int MAX_TRIES      = 3;
  localparam int UNLOCK_CYCLES  = 10;
  localparam int LOCKOUT_CYCLES = 20;

  typedef int seq_t [SEQ_LEN];

  logic       Clock    = 1'b0;
  logic       Reset    = 1'b1;
  logic       PulseA   = 1'b0;
  logic       PulseB   = 1'b0;
  logic       PulseC   = 1'b0;
  logic       ProgMode = 1'b0;
  logic       Locked;
  logic       Unlocked;
  logic       Error;
  logic [1:0] TriesLeft;
  logic [4:0] StateLeds;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  seq_t ABBAC = '{1, 2, 2, 1, 3};
  seq_t ABBAA = '{1, 2, 2, 1, 1};
  seq_t CCABA = '{3, 3, 1, 2, 1};

  seq_lock_ctrl #(
    .SEQ_LEN        (SEQ_LEN),
    .MAX_TRIES      (MAX_TRIES),
    .UNLOCK_CYCLES  (UNLOCK_CYCLES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .PulseA    (PulseA),
    .PulseB    (PulseB),
    .PulseC    (PulseC),
    .ProgMode  (ProgMode),
    .Locked    (Locked),
    .Unlocked  (Unlocked),
    .Error     (Error),
    .TriesLeft (TriesLeft),
    .StateLeds (StateLeds)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: open/lockout countdowns, entry queue, stored code.
  int m_code [SEQ_LEN];
  int m_entry [$];
  int m_open_left;
  int m_lock_left;
  int m_tries;
  bit m_prog;
  bit m_err;

  task automatic m_reset();
    m_code      = '{1, 2, 2, 1, 3};
    m_entry.delete();
    m_open_left = 0;
    m_lock_left = 0;
    m_tries     = MAX_TRIES;
    m_prog      = 1'b0;
    m_err       = 1'b0;
  endtask

  task automatic m_step();
    int s;
    bit ok;
    s = 0;
    if (PulseA + PulseB + PulseC == 1) s = PulseA ? 1 : (PulseB ? 2 : 3);
    m_err = 1'b0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_tries = MAX_TRIES;
    end else if (m_prog) begin
      if (!ProgMode) begin
        m_prog = 1'b0;
        m_entry.delete();
      end else if (s != 0) begin
        m_entry.push_back(s);
        if (m_entry.size() == SEQ_LEN) begin
          foreach (m_code[i]) m_code[i] = m_entry[i];
          m_entry.delete();
          m_prog = 1'b0;
        end
      end
    end else if (m_open_left > 0) begin
      if (ProgMode) begin
        m_prog      = 1'b1;
        m_open_left = 0;
      end else begin
        m_open_left--;
      end
    end else if (s != 0) begin
      m_entry.push_back(s);
      if (m_entry.size() == SEQ_LEN) begin
        ok = 1'b1;
        foreach (m_code[i]) if (m_entry[i] != m_code[i]) ok = 1'b0;
        m_entry.delete();
        if (ok) begin
          m_open_left = UNLOCK_CYCLES;
          m_tries     = MAX_TRIES;
        end else begin
          m_err = 1'b1;
          m_tries--;
          if (m_tries == 0) m_lock_left = LOCKOUT_CYCLES;
        end
      end
    end
  endtask

  function automatic logic [4:0] exp_leds();
    if (m_lock_left > 0)      return 5'b10000;
    if (m_prog)               return 5'b01000;
    if (m_open_left > 0)      return 5'b00100;
    if (m_entry.size() > 0)   return 5'b00010;
    return 5'b00001;
  endfunction

  always @(posedge Clock or posedge Reset) begin
    if (Reset) m_reset();
    else       m_step();
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge Clock) begin
    if (cmp_en) begin
      check("cmp_locked",   {31'b0, Locked},    {31'b0, !(m_open_left > 0 || m_prog)});
      check("cmp_unlocked", {31'b0, Unlocked},  {31'b0, (m_open_left > 0 || m_prog)});
      check("cmp_error",    {31'b0, Error},     {31'b0, m_err});
      check("cmp_tries",    {30'b0, TriesLeft}, m_tries);
      check("cmp_leds",     {27'b0, StateLeds}, {27'b0, exp_leds()});
    end
  end

  task automatic send(input int s);
    @(negedge Clock);
    PulseA = (s == 1);
    PulseB = (s == 2);
    PulseC = (s == 3);
    @(negedge Clock);
    PulseA = 1'b0;
    PulseB = 1'b0;
    PulseC = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic send_seq(input seq_t sq, input int gap);
    for (int i = 0; i < SEQ_LEN; i++) begin
      send(sq[i]);
      if (i < SEQ_LEN - 1) idle(gap - 2);
    end
  endtask

  task automatic wait_locked(input string name);
    int g;
    g = 0;
    while (Locked !== 1'b1 && g < 100) begin
      @(negedge Clock);
      g++;
    end
    check(name, {31'b0, Locked}, 32'd1);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_locked"},   {31'b0, Locked},    32'd1);
    check({name, "_unlocked"}, {31'b0, Unlocked},  32'd0);
    check({name, "_error"},    {31'b0, Error},     32'd0);
    check({name, "_tries"},    {30'b0, TriesLeft}, 32'd3);
    check({name, "_leds"},     {27'b0, StateLeds}, 32'd1);
  endtask

  task automatic async_reset(input string name);
    @(posedge Clock);
    #2;
    ProgMode = 1'b0;
    Reset    = 1'b1;
    #1;
    check_reset_vals(name);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    int n;
    int g;
    int t_lock;

    idle(2);
    Reset  = 1'b0;
    cmp_en = 1'b1;
    check_reset_vals("reset");

    // Correct code: open for exactly UNLOCK_CYCLES cycles.
    send_seq(ABBAC, 3);
    check("t1_unlocked", {31'b0, Unlocked}, 32'd1);
    check("t1_leds_open", {27'b0, StateLeds}, 32'b00100);
    n = 0;
    g = 0;
    while (Unlocked === 1'b1 && g < 50) begin
      n++;
      @(negedge Clock);
      g++;
    end
    check("t1_open_cycles", n, 10);
    check("t1_relocked", {31'b0, Locked}, 32'd1);
    check("t1_tries", {30'b0, TriesLeft}, 32'd3);

    // Three wrong entries lead to lockout; symbols ignored during it.
    t_lock = 0;
    for (int k = 1; k <= 3; k++) begin
      send_seq(ABBAA, 2);
      if (k == 3) t_lock = cyc;
      check("t2_error", {31'b0, Error}, 32'd1);
      check("t2_tries", {30'b0, TriesLeft}, 3 - k);
      @(negedge Clock);
      check("t2_error_clear", {31'b0, Error}, 32'd0);
    end
    check("t2_leds_lockout", {27'b0, StateLeds}, 32'b10000);
    send_seq(ABBAC, 2);
    check("t2_still_locked", {31'b0, Locked}, 32'd1);
    check("t2_leds_still_lockout", {27'b0, StateLeds}, 32'b10000);
    g = 0;
    while (StateLeds !== 5'b00001 && g < 60) begin
      @(negedge Clock);
      g++;
    end
    check("t2_lockout_cycles", cyc - t_lock, 20);
    check("t2_tries_restored", {30'b0, TriesLeft}, 32'd3);

    // Two buttons in one cycle are ignored mid-entry.
    send(1);
    send(2);
    @(negedge Clock);
    PulseA = 1'b1;
    PulseB = 1'b1;
    @(negedge Clock);
    PulseA = 1'b0;
    PulseB = 1'b0;
    check("t3_leds_enter", {27'b0, StateLeds}, 32'b00010);
    send(2);
    send(1);
    send(3);
    check("t3_unlocked", {31'b0, Unlocked}, 32'd1);
    wait_locked("t3_relock");

    // Reprogram to CCABA.
    send_seq(ABBAC, 2);
    check("t4_unlocked", {31'b0, Unlocked}, 32'd1);
    @(negedge Clock);
    ProgMode = 1'b1;
    @(negedge Clock);
    check("t4_leds_prog", {27'b0, StateLeds}, 32'b01000);
    send_seq(CCABA, 2);
    check("t4_locked", {31'b0, Locked}, 32'd1);
    check("t4_leds_idle", {27'b0, StateLeds}, 32'b00001);
    @(negedge Clock);
    ProgMode = 1'b0;
    send_seq(ABBAC, 2);
    check("t4_old_code_error", {31'b0, Error}, 32'd1);
    check("t4_old_code_tries", {30'b0, TriesLeft}, 32'd2);
    idle(1);
    send_seq(CCABA, 2);
    check("t4_new_code_unlocked", {31'b0, Unlocked}, 32'd1);
    check("t4_new_code_tries", {30'b0, TriesLeft}, 32'd3);
    wait_locked("t4_relock");

    // Reset during PROG restores the default code.
    send_seq(CCABA, 2);
    @(negedge Clock);
    ProgMode = 1'b1;
    idle(2);
    send(3);
    check("t6_leds_prog", {27'b0, StateLeds}, 32'b01000);
    async_reset("t6_prog_reset");
    send_seq(ABBAC, 2);
    check("t6_default_code_unlocked", {31'b0, Unlocked}, 32'd1);
    wait_locked("t6_relock");

    // Aborted programming keeps the code.
    send_seq(ABBAC, 2);
    @(negedge Clock);
    ProgMode = 1'b1;
    idle(2);
    send(3);
    send(3);
    @(negedge Clock);
    ProgMode = 1'b0;
    idle(1);
    check("t5_abort_locked", {31'b0, Locked}, 32'd1);
    check("t5_abort_leds", {27'b0, StateLeds}, 32'b00001);
    send_seq(ABBAC, 2);
    check("t5_code_kept", {31'b0, Unlocked}, 32'd1);
    wait_locked("t5_relock");

    // Reset mid-entry at idx=3.
    send(1);
    send(2);
    send(2);
    check("t7_leds_enter", {27'b0, StateLeds}, 32'b00010);
    async_reset("t7_enter_reset");
    send_seq(ABBAC, 2);
    check("t7_unlock_after_reset", {31'b0, Unlocked}, 32'd1);
    wait_locked("t7_relock");

    idle(2);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
